// File: rtl/beat_recorder_core.sv
// Record/playback engine: captures timed key-code events into per-slot memories
// and replays a chosen slot with the same inter-event timing on note_out.
module beat_recorder_core #(
  parameter int NUM_SLOTS = 3,
  parameter int DEPTH     = 64,
  parameter int TICK_DIV  = 50000,
  parameter int TIME_W    = 16,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           ascii,
  input  logic                 record_toggle,
  input  logic                 play_req,
  input  logic [SLOT_W-1:0]    slot_sel,
  output logic [6:0]           note_out,
  output logic                 recording,
  output logic                 playing,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 overflow
);
  localparam int PTR_W  = $clog2(DEPTH + 1);
  localparam int MEM_N  = NUM_SLOTS * DEPTH;
  localparam int ADDR_W = (MEM_N > 1) ? $clog2(MEM_N) : 1;
  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ENT_W  = TIME_W + 7;
  localparam logic [TIME_W-1:0] DELTA_MAX = '1;
  localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY_FETCH, S_PLAY_WAIT} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    tick_cnt_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [TIME_W-1:0]   delta_q;
  logic [TIME_W-1:0]   wait_q;
  logic [6:0]          prev_ascii_q;
  logic [6:0]          code_q;
  logic [6:0]          note_q;
  logic                recording_q;
  logic                playing_q;
  logic                overflow_q;
  logic                fetch_pend_q;
  logic [PTR_W-1:0]    slot_len_q [NUM_SLOTS];
  logic [ENT_W-1:0]    mem [MEM_N];
  logic [ENT_W-1:0]    rd_data_q;

  logic                tick;
  logic                key_event;
  logic                slot_sel_ok;
  logic                mem_we;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [SLOT_W-1:0] s,
                                                input logic [PTR_W-1:0]  p);
    return ADDR_W'(s) * ADDR_W'(DEPTH) + ADDR_W'(p);
  endfunction

  assign tick        = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign key_event   = (ascii != prev_ascii_q);
  // Out-of-range slot numbers (non power-of-two NUM_SLOTS) never start anything.
  assign slot_sel_ok = (int'(slot_sel) < NUM_SLOTS);
  assign mem_we      = (state_q == S_REC) && key_event && (wr_ptr_q < DEPTH_P);
  assign wr_addr     = addr_of(slot_q, wr_ptr_q);
  assign rd_addr     = addr_of(slot_q, rd_ptr_q);

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= {delta_q, ascii};
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      slot_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      delta_q      <= '0;
      wait_q       <= '0;
      prev_ascii_q <= '0;
      code_q       <= '0;
      note_q       <= '0;
      recording_q  <= 1'b0;
      playing_q    <= 1'b0;
      overflow_q   <= 1'b0;
      fetch_pend_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_len_q[i] <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      if (record_toggle && (state_q == S_PLAY_FETCH || state_q == S_PLAY_WAIT)) begin
        state_q    <= S_IDLE;
        playing_q  <= 1'b0;
        note_q     <= '0;
        tick_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            note_q <= '0;
            if (record_toggle && slot_sel_ok) begin
              state_q      <= S_REC;
              recording_q  <= 1'b1;
              tick_cnt_q   <= '0;
              slot_q       <= slot_sel;
              wr_ptr_q     <= '0;
              delta_q      <= '0;
              overflow_q   <= 1'b0;
              prev_ascii_q <= ascii;
            end else if (play_req && slot_sel_ok && slot_len_q[slot_sel] != '0) begin
              state_q      <= S_PLAY_FETCH;
              playing_q    <= 1'b1;
              tick_cnt_q   <= '0;
              slot_q       <= slot_sel;
              rd_ptr_q     <= '0;
              fetch_pend_q <= 1'b1;
            end
          end
          S_REC: begin
            if (tick && delta_q != DELTA_MAX) delta_q <= delta_q + 1'b1;
            if (key_event) begin
              prev_ascii_q <= ascii;
              if (wr_ptr_q < DEPTH_P) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                delta_q  <= '0;
              end else begin
                overflow_q <= 1'b1;
              end
            end
            // An event coinciding with the stop pulse is written and counted.
            if (record_toggle) begin
              state_q            <= S_IDLE;
              recording_q        <= 1'b0;
              tick_cnt_q         <= '0;
              slot_len_q[slot_q] <= wr_ptr_q + PTR_W'(mem_we);
            end
          end
          S_PLAY_FETCH: begin
            // First cycle issues the read; the entry is in rd_data_q on the second.
            if (fetch_pend_q) begin
              fetch_pend_q <= 1'b0;
            end else begin
              wait_q     <= rd_data_q[ENT_W-1:7];
              code_q     <= rd_data_q[6:0];
              state_q    <= S_PLAY_WAIT;
              tick_cnt_q <= '0;
            end
          end
          S_PLAY_WAIT: begin
            if (wait_q == '0 || (tick && wait_q == TIME_W'(1))) begin
              note_q     <= code_q;
              rd_ptr_q   <= rd_ptr_q + 1'b1;
              tick_cnt_q <= '0;
              if (rd_ptr_q + 1'b1 == slot_len_q[slot_q]) begin
                state_q   <= S_IDLE;
                playing_q <= 1'b0;
              end else begin
                state_q      <= S_PLAY_FETCH;
                fetch_pend_q <= 1'b1;
              end
            end else if (tick) begin
              wait_q <= wait_q - 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_valid
    assign slot_valid[gi] = (slot_len_q[gi] != '0);
  end

  assign note_out  = note_q;
  assign recording = recording_q;
  assign playing   = playing_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_beat_recorder_core.sv
// Directed plus randomized bench for beat_recorder_core; a per-slot event list model
// predicts stored notes and replay timing in ticks.
module tb_beat_recorder_core;
  localparam int NS = 3, DP = 4, TD = 4, TW = 4, SW = 2;
  localparam int TMAX = (1 << TW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            record_toggle = 1'b0;
  logic            play_req = 1'b0;
  logic [6:0]      ascii = '0;
  logic [SW-1:0]   slot_sel = '0;
  logic [6:0]      note_out;
  logic            recording, playing, overflow;
  logic [NS-1:0]   slot_valid;

  int checks = 0;
  int passes = 0;
  typedef struct {longint t; int v;} ev_t;
  ev_t  mon_q[$];
  logic [6:0] last_note = '0;
  int mcode[NS][16];
  int mtick[NS][16];
  int mlen[NS];
  int rc[$];
  int rg[$];
  int n_r, c_r, p_r, k_r;

  beat_recorder_core #(.NUM_SLOTS(NS), .DEPTH(DP), .TICK_DIV(TD), .TIME_W(TW), .SLOT_W(SW)) dut (
    .clk(clk), .reset(reset), .ascii(ascii), .record_toggle(record_toggle),
    .play_req(play_req), .slot_sel(slot_sel), .note_out(note_out),
    .recording(recording), .playing(playing), .slot_valid(slot_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (note_out !== last_note) begin
      ev_t e;
      e.t = $time;
      e.v = int'(note_out);
      mon_q.push_back(e);
      last_note = note_out;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) passes++;
    else $error("FAIL %s: observed=%0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  function automatic int valid_model();
    int v = 0;
    for (int i = 0; i < NS; i++) if (mlen[i] > 0) v |= (1 << i);
    return v;
  endfunction

  // Records rc[] with gaps rg[] (cycles) into a slot; updates the model.
  task automatic record(input int slot, input bit stop_with_last);
    int n = rc.size();
    slot_sel = SW'(slot);
    record_toggle = 1'b1;
    cyc(1);
    record_toggle = 1'b0;
    chk("rec_flag", int'(recording), 1);
    mlen[slot] = 0;
    for (int i = 0; i < n; i++) begin
      cyc(i == 0 ? rg[i] - 1 : rg[i]);
      ascii = 7'(rc[i]);
      if (i == n - 1 && stop_with_last) record_toggle = 1'b1;
      if (i < DP) begin
        mcode[slot][i] = rc[i];
        mtick[slot][i] = (rg[i] / TD > TMAX) ? TMAX : rg[i] / TD;
        mlen[slot] = i + 1;
      end
    end
    if (!stop_with_last) begin
      cyc(3);
      record_toggle = 1'b1;
    end
    cyc(1);
    record_toggle = 1'b0;
    ascii = '0;
    cyc(1);
    chk("rec_stop", int'(recording), 0);
    chk("overflow", int'(overflow), (n > DP) ? 1 : 0);
    chk("slot_valid", int'(slot_valid), valid_model());
  endtask

  task automatic play_check(input int slot, input string tag);
    longint t0, prev;
    int gap, lo, hi, k;
    int ev[$];
    mon_q.delete();
    slot_sel = SW'(slot);
    play_req = 1'b1;
    t0 = $time;
    cyc(1);
    play_req = 1'b0;
    chk({tag, "_playing"}, int'(playing), 1);
    k = 0;
    while (playing && k < 5000) begin
      cyc(1);
      k++;
    end
    chk({tag, "_done"}, int'(playing), 0);
    cyc(2);
    for (int i = 0; i < mlen[slot]; i++) ev.push_back(mcode[slot][i]);
    if (ev.size() > 0 && ev[ev.size() - 1] != 0) ev.push_back(0);
    chk({tag, "_count"}, mon_q.size(), ev.size());
    prev = t0;
    for (int i = 0; i < ev.size() && i < mon_q.size(); i++) begin
      chk($sformatf("%s_code%0d", tag, i), mon_q[i].v, ev[i]);
      if (i < mlen[slot]) begin
        gap = int'((mon_q[i].t - prev) / 10);
        lo = (mtick[slot][i] - 1) * TD;
        if (lo < 0) lo = 0;
        hi = (mtick[slot][i] + 1) * TD + 4;
        chk_rng($sformatf("%s_gap%0d", tag, i), gap, lo, hi);
        prev = mon_q[i].t;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) mlen[i] = 0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_note", int'(note_out), 0);
    chk("rst_rec", int'(recording), 0);
    chk("rst_play", int'(playing), 0);
    chk("rst_valid", int'(slot_valid), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Basic: 'a' at 10 ticks, release at 15, 's' at 20.
    rc = '{'h61, 0, 'h73};
    rg = '{42, 20, 20};
    record(1, 1'b0);
    chk("basic_valid", int'(slot_valid), 'b010);
    play_check(1, "basic");

    // Overflow: six key changes into a four-entry slot.
    rc = '{'h61, 'h62, 'h63, 'h64, 'h65, 'h66};
    rg = '{5, 6, 7, 8, 9, 10};
    record(0, 1'b0);
    play_check(0, "ovf");

    // Abort during PLAY_WAIT, then replay intact.
    slot_sel = SW'(1);
    play_req = 1'b1;
    cyc(1);
    play_req = 1'b0;
    k_r = 0;
    while (note_out == '0 && k_r < 2000) begin
      cyc(1);
      k_r++;
    end
    chk("abort_first", int'(note_out), 'h61);
    cyc(5);
    record_toggle = 1'b1;
    cyc(1);
    record_toggle = 1'b0;
    chk("abort_note", int'(note_out), 0);
    chk("abort_play", int'(playing), 0);
    chk("abort_rec", int'(recording), 0);
    cyc(3);
    chk("abort_rec_later", int'(recording), 0);
    play_check(1, "replay");

    // Saturation: 40-tick gap, then an event coincident with the stop pulse.
    rc = '{'h78, 'h7a};
    rg = '{160, 12};
    record(2, 1'b1);
    play_check(2, "sat");

    // Record wins over play in the same cycle; empty recording clears slot 2.
    slot_sel = SW'(2);
    record_toggle = 1'b1;
    play_req = 1'b1;
    cyc(1);
    record_toggle = 1'b0;
    play_req = 1'b0;
    chk("prio_rec", int'(recording), 1);
    chk("prio_play", int'(playing), 0);
    cyc(3);
    record_toggle = 1'b1;
    cyc(1);
    record_toggle = 1'b0;
    mlen[2] = 0;
    chk("prio_stop", int'(recording), 0);
    chk("prio_valid", int'(slot_valid), valid_model());
    play_req = 1'b1;
    cyc(1);
    play_req = 1'b0;
    chk("empty_play", int'(playing), 0);
    cyc(3);
    chk("empty_play_later", int'(playing), 0);

    // Randomized recordings into slot 0.
    for (int r = 0; r < 3; r++) begin
      n_r = int'($urandom_range(1, 6));
      p_r = 0;
      rc.delete();
      rg.delete();
      for (int i = 0; i < n_r; i++) begin
        do c_r = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range('h61, 'h7a));
        while (c_r == p_r);
        rc.push_back(c_r);
        rg.push_back(int'($urandom_range(1, 12 * TD)));
        p_r = c_r;
      end
      record(0, 1'($urandom_range(0, 1)));
      play_check(0, $sformatf("rnd%0d", r));
    end

    // Reset during playback clears everything.
    slot_sel = SW'(1);
    play_req = 1'b1;
    cyc(1);
    play_req = 1'b0;
    cyc(10);
    chk("rst2_pre_play", int'(playing), 1);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < NS; i++) mlen[i] = 0;
    chk("rst2_note", int'(note_out), 0);
    chk("rst2_play", int'(playing), 0);
    chk("rst2_rec", int'(recording), 0);
    chk("rst2_valid", int'(slot_valid), valid_model());
    chk("rst2_ovf", int'(overflow), 0);
    slot_sel = SW'(0);
    play_req = 1'b1;
    cyc(1);
    play_req = 1'b0;
    chk("rst2_play_ign", int'(playing), 0);
    cyc(5);
    chk("rst2_play_ign_later", int'(playing), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/beat_recorder_core.md
Name: beat_recorder_core

Overview:
Parametrised record/playback engine for the beat recorder. Captures keyboard note events (7-bit ASCII codes) with tick-resolution timing into one of NUM_SLOTS event memories, then replays a selected slot with the same timing on note_out. Sits between the PS/2 decode path and the tone/buzzer generator. Generalises the fixed three-register scheme to N slots of DEPTH events each, with timestamps, overflow reporting and playback abort.

Parameters:
NUM_SLOTS, 3, number of independent recording slots
DEPTH, 64, events stored per slot
TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz)
TIME_W, 16, width of stored inter-event delta in ticks
SLOT_W, $clog2(NUM_SLOTS) (min 1), width of slot_sel

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high
ascii  in  7  current key code from keyboard decoder; 0 = no key
record_toggle  in  1  single-cycle pulse, debounced upstream; start/stop recording
play_req  in  1  single-cycle pulse; start playback of slot_sel
slot_sel  in  SLOT_W  target slot; sampled only when a record or play starts
note_out  out  7  playback note code; 0 = silence
recording  out  1  high in REC state
playing  out  1  high in PLAY state
slot_valid  out  NUM_SLOTS  bit i set when slot i holds ≥1 event
overflow  out  1  sticky: last recording hit DEPTH and dropped events

Behaviour:
- Reset: state IDLE; note_out=0, recording=0, playing=0, slot_valid=0, overflow=0; all slot lengths=0, tick divider=0, delta counter=0, prev_ascii=0. Memory contents are don't-care.
- Tick: free-running divider; tick=1 for one cycle every TICK_DIV clks. Cleared on every state entry.
- States: IDLE, REC, PLAY_FETCH, PLAY_WAIT.
- IDLE: record_toggle -> REC, latch slot, wr_ptr=0, delta=0, overflow=0, prev_ascii=ascii. Otherwise play_req with slot_len[slot_sel]>0 -> PLAY_FETCH. play_req on an empty slot is ignored (stay IDLE, playing stays 0). If both pulses arrive in the same cycle, record wins.
- REC: delta increments on each tick and saturates at 2^TIME_W-1. On any cycle where ascii != prev_ascii:
  - If wr_ptr<DEPTH: write {delta, ascii} at wr_ptr, wr_ptr++, delta=0.
  - Else: drop the event and set overflow.
  - In both cases prev_ascii=ascii.
  - Key releases (ascii→0) are events.
- REC exit: record_toggle -> IDLE, slot_len=wr_ptr, slot_valid[slot]=(wr_ptr!=0). An event on the same cycle as the stop is recorded first. play_req is ignored in REC. A new recording overwrites the slot.
- PLAY_FETCH: synchronous memory read; entry rd_ptr is available one cycle later. Load wait=delta_entry and clear the tick count -> PLAY_WAIT. rd_ptr=0 on entry from IDLE.
- PLAY_WAIT: when wait==0, or on the tick that decrements wait to 0, note_out=code_entry and rd_ptr++. If rd_ptr+1==slot_len -> IDLE with note_out=0 on the following cycle; else -> PLAY_FETCH.
  - Delta-0 entries therefore emit on the cycle after fetch completes.
  - Worst-case added latency is 2 clks per event, non-cumulative against tick timing error of ≤1 tick.
- PLAY abort: record_toggle in PLAY_* -> IDLE immediately, note_out=0. Recording does not start; a second pulse is needed. play_req during PLAY is ignored.
- reset mid-record or mid-play: returns to IDLE and clears all slot lengths; the recording is lost.
- recording/playing are registered decodes of state. Outputs change only on clk edges.

Test Plan:
- Reset: assert reset 2 clks during PLAY -> next cycle all outputs 0, slot_valid=0, play_req on slot 0 ignored.
- Basic record/play (TICK_DIV=4, slot 1): toggle; ascii 'a'(0x61) at t=10 ticks, 0 at t=15, 's'(0x73) at t=20; toggle -> slot_valid=3'b010, slot_len=3. play_req slot 1 -> note_out 0x61 at ~10 ticks, 0 at +5, 0x73 at +5 (±1 tick, ±2 clk), then 0 and playing=0.
- Overflow (DEPTH=4): record 6 key changes -> overflow=1, only first 4 replayed, slot_valid set.
- Empty slot / priority: play_req on slot 2 never recorded -> playing stays 0. Record_toggle+play_req same cycle in IDLE -> recording=1.
- Abort: record_toggle during PLAY_WAIT -> note_out=0 and IDLE next cycle, recording=0. Slot contents intact; replay matches original.
- Saturation (TIME_W=4): 40-tick gap before key -> stored delta 15, replay gap 15 ticks. Event coincident with stop toggle is stored.
